// File: rtl/beat_pkg.sv
// Shared types and constants for the record/playback slot controller.
// Holds the FSM encoding, default widths and the slot-select decode.
package beat_pkg;

    localparam int DEF_NOTE_W = 4;
    localparam int DEF_PTR_W  = 10;
    localparam int NUM_SLOTS  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY,
        PLAY_FETCH
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } slot_sel_t;

    // Lowest set switch wins; no switch set means no usable slot.
    function automatic slot_sel_t decode_slot(input logic [2:0] sw);
        slot_sel_t sel;
        sel = '0;
        if (sw[0]) begin
            sel.valid = 1'b1;
            sel.idx   = 2'd0;
        end else if (sw[1]) begin
            sel.valid = 1'b1;
            sel.idx   = 2'd1;
        end else if (sw[2]) begin
            sel.valid = 1'b1;
            sel.idx   = 2'd2;
        end
        return sel;
    endfunction

endpackage

// File: rtl/slot_len_table.sv
// Recorded length per slot, one write port, clear-all and an indexed read.
// Lengths are PTR_W+1 bits so a completely full slot is representable.
module slot_len_table
    import beat_pkg::*;
#(
    parameter int LEN_W = DEF_PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             we,
    input  logic [1:0]       wr_idx,
    input  logic [LEN_W-1:0] wdata,
    input  logic [1:0]       rd_idx,
    output logic [LEN_W-1:0] rdata
);

    localparam logic [1:0] LAST_IDX = 2'(NUM_SLOTS - 1);

    logic [LEN_W-1:0] len_q [NUM_SLOTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
        end else if (we && wr_idx <= LAST_IDX) begin
            len_q[wr_idx] <= wdata;
        end
    end

    assign rdata = (rd_idx <= LAST_IDX) ? len_q[rd_idx] : '0;

endmodule

// File: rtl/record_slot_controller.sv
// Three-slot note recorder: captures note codes on sample ticks into
// external memory and plays them back through a one-cycle fetch.
module record_slot_controller
    import beat_pkg::*;
#(
    parameter int NOTE_W = DEF_NOTE_W,
    parameter int PTR_W  = DEF_PTR_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              rec_pulse,
    input  logic              play_pulse,
    input  logic              clear_pulse,
    input  logic [2:0]        slot_sw,
    input  logic              sample_tick,
    input  logic [NOTE_W-1:0] note_in,
    output logic [PTR_W+1:0]  mem_addr,
    output logic              mem_we,
    output logic [NOTE_W-1:0] mem_wdata,
    input  logic [NOTE_W-1:0] mem_rdata,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_valid,
    output logic              recording,
    output logic              playing,
    output logic              done
);

    localparam int LEN_W = PTR_W + 1;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, ptr_next;
    logic [1:0]        slot, slot_next;
    logic [NOTE_W-1:0] held_note;
    logic              done_next;
    slot_sel_t         sel;
    logic [1:0]        tbl_idx;
    logic              len_we;
    logic [LEN_W-1:0]  len_wdata;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  ptr_inc;

    assign sel     = decode_slot(slot_sw);
    // Before a slot is latched the switches address the table directly.
    assign tbl_idx = (state == IDLE) ? sel.idx : slot;
    assign ptr_inc = LEN_W'(ptr) + LEN_W'(1);

    slot_len_table #(
        .LEN_W(LEN_W)
    ) u_len (
        .clk   (CLOCK_50),
        .reset (reset),
        .clear (clear_pulse),
        .we    (len_we),
        .wr_idx(tbl_idx),
        .wdata (len_wdata),
        .rd_idx(tbl_idx),
        .rdata (cur_len)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            slot      <= '0;
            held_note <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            slot      <= slot_next;
            held_note <= note_out;
            done      <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        slot_next  = slot;
        done_next  = 1'b0;
        len_we     = 1'b0;
        len_wdata  = '0;
        mem_we     = 1'b0;
        if (clear_pulse) begin
            state_next = IDLE;
            ptr_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rec_pulse && sel.valid) begin
                        state_next = RECORD;
                        ptr_next   = '0;
                        slot_next  = sel.idx;
                        len_we     = 1'b1;
                    end else if (play_pulse && sel.valid) begin
                        if (cur_len != '0) begin
                            state_next = PLAY;
                            ptr_next   = '0;
                            slot_next  = sel.idx;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                RECORD: begin
                    if (sample_tick) begin
                        mem_we = 1'b1;
                        if (rec_pulse || (&ptr)) begin
                            state_next = IDLE;
                            ptr_next   = '0;
                            len_we     = 1'b1;
                            len_wdata  = ptr_inc;
                            done_next  = 1'b1;
                        end else begin
                            ptr_next = ptr + PTR_W'(1);
                        end
                    end else if (rec_pulse) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                        len_we     = 1'b1;
                        len_wdata  = LEN_W'(ptr);
                        done_next  = 1'b1;
                    end
                end
                PLAY: begin
                    if (play_pulse) begin
                        ptr_next = '0;
                    end else if (sample_tick) begin
                        state_next = PLAY_FETCH;
                    end
                end
                PLAY_FETCH: begin
                    if (ptr_inc == cur_len) begin
                        state_next = IDLE;
                        ptr_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = PLAY;
                        ptr_next   = ptr + PTR_W'(1);
                    end
                end
            endcase
        end
    end

    assign mem_addr   = {slot, ptr};
    assign mem_wdata  = mem_we ? note_in : '0;
    // Read data arrives during the fetch cycle and is shown immediately.
    assign note_valid = (state == PLAY_FETCH) && !clear_pulse;
    assign note_out   = note_valid ? mem_rdata : held_note;
    assign recording  = (state == RECORD);
    assign playing    = (state == PLAY) || (state == PLAY_FETCH);

endmodule

// File: doc/record_slot_controller.md
RECORD_SLOT_CONTROLLER -- requirements
Module: record_slot_controller

Interface
REQ-001 Parameter NOTE_W, default 4, SHALL set the width of the keyboard note code.
REQ-002 Parameter PTR_W, default 10, SHALL set the sample pointer width; DEPTH = 2**PTR_W samples per slot.
REQ-003 CLOCK_50  in  1  single system clock; all logic SHALL be rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rec_pulse  in  1  one-cycle record/stop request (debounced KEY0).
REQ-006 play_pulse  in  1  one-cycle playback request.
REQ-007 clear_pulse  in  1  one-cycle erase-all request (debounced KEY3).
REQ-008 slot_sw  in  3  slot select switches; bit n selects slot n.
REQ-009 sample_tick  in  1  one-cycle sample-rate strobe.
REQ-010 note_in  in  NOTE_W  live keyboard note code to record.
REQ-011 mem_addr  out  2+PTR_W  sample memory address, {slot, ptr}.
REQ-012 mem_we  out  1  memory write enable.
REQ-013 mem_wdata  out  NOTE_W  memory write data.
REQ-014 mem_rdata  in  NOTE_W  memory read data, valid one cycle after mem_addr.
REQ-015 note_out  out  NOTE_W  played-back note code.
REQ-016 note_valid  out  1  one-cycle strobe when note_out updates.
REQ-017 recording, playing  out  1 each  state indicators.
REQ-018 done  out  1  one-cycle pulse at end of a record or playback.

Function
REQ-019 States SHALL be IDLE, RECORD, PLAY, PLAY_FETCH.
REQ-020 Slot index SHALL be the lowest set bit of slot_sw; slot_sw==0 is invalid, and rec/play requests are then ignored.
REQ-021 Slot index SHALL be latched on leaving IDLE; slot_sw changes are ignored until IDLE is reached again.
REQ-022 IDLE + rec_pulse (valid slot) -> RECORD; ptr:=0; len[slot]:=0.
REQ-023 IDLE + play_pulse (valid slot, len>0) -> PLAY; ptr:=0.
REQ-024 IDLE + play_pulse with len[slot]==0 -> stay IDLE; done pulses next cycle.
REQ-025 rec_pulse and play_pulse asserted together in IDLE: record SHALL win.
REQ-026 RECORD: each sample_tick -> mem_we=1 for that cycle, mem_wdata=note_in, mem_addr={slot,ptr}; ptr++.
REQ-027 RECORD + rec_pulse -> IDLE; len[slot]:=ptr; done pulse; a same-cycle tick SHALL still write first and be counted.
REQ-028 RECORD write at ptr==DEPTH-1 -> len[slot]:=DEPTH (PTR_W+1 bits); auto-stop to IDLE; done pulse.
REQ-029 PLAY: sample_tick -> drive mem_addr={slot,ptr}; go PLAY_FETCH.
REQ-030 PLAY_FETCH (one cycle): note_out:=mem_rdata; note_valid=1; ptr++; if ptr+1==len -> IDLE with done, else PLAY.
REQ-031 play_pulse during RECORD and rec_pulse during PLAY/PLAY_FETCH SHALL be ignored; play_pulse during PLAY SHALL restart at ptr=0.
REQ-032 clear_pulse in any state -> all len:=0; abort to IDLE; mem_we=0; no done pulse; takes priority over all other requests.
REQ-033 mem_we SHALL only assert in RECORD on a tick.
REQ-034 recording=1 exactly in RECORD; playing=1 in PLAY or PLAY_FETCH.

Reset
REQ-035 reset SHALL force state IDLE, ptr=0, all len=0, slot=0, note_out=0, note_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0.
REQ-036 Reset asserted mid-record or mid-play SHALL abort immediately with no done pulse and no memory write.

Structure
REQ-037 State encoding, NOTE_W/PTR_W defaults and NUM_SLOTS=3 SHALL live in shared package beat_pkg.
REQ-038 Slot length registers SHALL be one sub-module, slot_len_table (3 entries, write port, clear-all, read by index).

Verification
REQ-039 slot_sw=3'b010, rec_pulse, 5 ticks with note_in=1..5, rec_pulse -> 5 writes at addr {1,0..4}; len[1]=5; done once.
REQ-040 Then play_pulse with a memory model -> note_out 1,2,3,4,5 each one cycle after tick; done after 5th; playing drops.
REQ-041 Record DEPTH+3 ticks -> exactly DEPTH writes; auto-stop at DEPTH; len=DEPTH; done.
REQ-042 play_pulse on empty slot 2 -> no memory read, done pulse next cycle, stays IDLE.
REQ-043 clear_pulse mid-PLAY -> IDLE next cycle, no done; subsequent play on any slot acts as empty.
REQ-044 Async reset mid-RECORD, not clock-aligned -> outputs zero immediately; len[slot]=0.
